// File: rtl/nanorv32_mem_arbiter_if.sv
// CPU-side code/data request-acknowledge bundle for nanorv32_mem_arbiter.
// master = core side, slave = memory responder side.
interface nanorv32_mem_arbiter_if;

    logic        cpu_codemem_req;
    logic [31:0] cpu_codemem_addr;
    logic        codemem_cpu_ack;
    logic [31:0] codemem_cpu_rdata;

    logic        cpu_datamem_req;
    logic [31:0] cpu_datamem_addr;
    logic [31:0] cpu_datamem_wdata;
    logic [3:0]  cpu_datamem_bytesel;
    logic        datamem_cpu_ack;
    logic [31:0] datamem_cpu_rdata;

    modport master (
        output cpu_codemem_req,
        output cpu_codemem_addr,
        input  codemem_cpu_ack,
        input  codemem_cpu_rdata,
        output cpu_datamem_req,
        output cpu_datamem_addr,
        output cpu_datamem_wdata,
        output cpu_datamem_bytesel,
        input  datamem_cpu_ack,
        input  datamem_cpu_rdata
    );

    modport slave (
        input  cpu_codemem_req,
        input  cpu_codemem_addr,
        output codemem_cpu_ack,
        output codemem_cpu_rdata,
        input  cpu_datamem_req,
        input  cpu_datamem_addr,
        input  cpu_datamem_wdata,
        input  cpu_datamem_bytesel,
        output datamem_cpu_ack,
        output datamem_cpu_rdata
    );

endinterface

// File: rtl/nanorv32_mem_arbiter.sv
// Serves nanorv32 code and data ports from one synchronous byte-write RAM.
// Define NANORV32_ARB_RR_EN for round-robin arbitration (default: data wins).
module nanorv32_mem_arbiter #(
    parameter int         AW   = 15,
    parameter logic [3:0] BASE = 4'h0
) (
    input  logic                   clk,
    input  logic                   rst,
    nanorv32_mem_arbiter_if.slave  cpu,
    output logic [AW-3:0]          ram_addr,
    output logic [3:0]             ram_we,
    output logic [31:0]            ram_din,
    input  logic [31:0]            ram_dout
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] RD_CODE = 2'd1;
    localparam logic [1:0] RD_DATA = 2'd2;
    localparam logic [1:0] RD_NULL = 2'd3;

    logic [1:0] state_q;
    logic [1:0] state_d;
    logic       null_data_q;
    logic       null_data_d;

    logic       code_req;
    logic       data_req;
    logic       code_win;
    logic       data_win;
    logic       is_store;
    logic       prefer_data;
    logic       grant_code;
    logic       grant_data;

    assign code_req = cpu.cpu_codemem_req;
    assign data_req = cpu.cpu_datamem_req;
    assign code_win = (cpu.cpu_codemem_addr[31:28] == BASE);
    assign data_win = (cpu.cpu_datamem_addr[31:28] == BASE);
    assign is_store = (cpu.cpu_datamem_bytesel != 4'b0000);
    assign ram_din  = cpu.cpu_datamem_wdata;

`ifdef NANORV32_ARB_RR_EN
    // last_grant_q: 1 = data port was granted last, 0 = code port
    logic last_grant_q;
    logic last_grant_d;

    assign prefer_data = ~last_grant_q;

    always_comb begin
        last_grant_d = last_grant_q;
        if (grant_data) begin
            last_grant_d = 1'b1;
        end else if (grant_code) begin
            last_grant_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`else
    assign prefer_data = 1'b1;
`endif

    always_comb begin
        grant_data = 1'b0;
        grant_code = 1'b0;
        if (!rst && (state_q == IDLE)) begin
            grant_data = data_req & (~code_req | prefer_data);
            grant_code = code_req & ~grant_data;
        end
    end

    always_comb begin
        state_d               = state_q;
        null_data_d           = null_data_q;
        ram_addr              = '0;
        ram_we                = 4'b0000;
        cpu.codemem_cpu_ack   = 1'b0;
        cpu.codemem_cpu_rdata = 32'h0;
        cpu.datamem_cpu_ack   = 1'b0;
        cpu.datamem_cpu_rdata = 32'h0;
        unique case (state_q)
            IDLE: begin
                if (grant_data) begin
                    ram_addr = cpu.cpu_datamem_addr[AW-1:2];
                    if (is_store) begin
                        // stores complete in the grant cycle
                        cpu.datamem_cpu_ack = 1'b1;
                        if (data_win) begin
                            ram_we = cpu.cpu_datamem_bytesel;
                        end
                    end else begin
                        state_d     = data_win ? RD_DATA : RD_NULL;
                        null_data_d = 1'b1;
                    end
                end else if (grant_code) begin
                    ram_addr    = cpu.cpu_codemem_addr[AW-1:2];
                    state_d     = code_win ? RD_CODE : RD_NULL;
                    null_data_d = 1'b0;
                end
            end
            RD_CODE: begin
                state_d = IDLE;
                if (!rst) begin
                    cpu.codemem_cpu_ack   = 1'b1;
                    cpu.codemem_cpu_rdata = ram_dout;
                end
            end
            RD_DATA: begin
                state_d = IDLE;
                if (!rst) begin
                    cpu.datamem_cpu_ack   = 1'b1;
                    cpu.datamem_cpu_rdata = ram_dout;
                end
            end
            RD_NULL: begin
                state_d = IDLE;
                if (!rst) begin
                    cpu.datamem_cpu_ack = null_data_q;
                    cpu.codemem_cpu_ack = ~null_data_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            null_data_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            null_data_q <= null_data_d;
        end
    end

    logic unused_addr_bits;
    assign unused_addr_bits = ^{cpu.cpu_codemem_addr[27:AW],
                                cpu.cpu_codemem_addr[1:0],
                                cpu.cpu_datamem_addr[27:AW],
                                cpu.cpu_datamem_addr[1:0]};

endmodule
